// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store alignment unit: funct3 codes, FSM states,
// base byte-enable patterns and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Stores only know B/H/W; loads add the unsigned byte/half forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] base_be(input logic [2:0] f3);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_B;
            2'b01:   be = BE_H;
            2'b10:   be = BE_W;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Combinational lane steering: builds the two-word byte-enable/write-data image of
// a store and extracts/extends load data from the two captured words.
import lsu_pkg::*;

module lsu_lane_shift (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  wide_be,
    output logic [63:0] wide_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Store side: slide enables and data up by the byte offset across an 8-lane window.
    always_comb begin
        wide_be    = {4'b0000, base_be(funct3)} << off;
        wide_wdata = {32'h0000_0000, wdata} << {off, 3'b000};
    end

    // Load side: bring the addressed bytes down to lane 0, then size and extend.
    always_comb begin
        shifted = 32'({hi, lo} >> {off, 3'b000});
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = shifted;
            F3_BU:   load_data = {24'h00_0000, shifted[7:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns one RV32 load/store into one or two word-aligned
// byte-enabled memory accesses and returns extended load data.
import lsu_pkg::*;

module lsu_align #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;
    logic                  wr_q;

    logic [2:0]            sel_f3;
    logic [1:0]            sel_off;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] lo_in;
    logic [DATA_WIDTH-1:0] hi_in;
    logic [7:0]            wide_be;
    logic [63:0]           wide_wdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  legal;
    logic                  accept;
    logic                  split;
    logic [ADDR_WIDTH-1:0] base_addr;

    // In IDLE the lane logic looks at the incoming request so ACC0 outputs can be registered at accept.
    always_comb begin
        if (state == IDLE) begin
            sel_f3    = req_funct3;
            sel_off   = req_addr[1:0];
            sel_wdata = req_wdata;
        end else begin
            sel_f3    = f3_q;
            sel_off   = addr_q[1:0];
            sel_wdata = wdata_q;
        end
    end

    // The word being read this cycle is folded in before it lands in lo/hi.
    always_comb begin
        lo_in = lo;
        hi_in = hi;
        if (state == ACC0) begin
            lo_in = mem_rdata;
        end else if (state == ACC1) begin
            hi_in = mem_rdata;
        end else begin
            lo_in = lo;
            hi_in = hi;
        end
    end

    lsu_lane_shift u_lane_shift (
        .funct3     (sel_f3),
        .off        (sel_off),
        .wdata      (sel_wdata),
        .lo         (lo_in),
        .hi         (hi_in),
        .wide_be    (wide_be),
        .wide_wdata (wide_wdata),
        .load_data  (load_data)
    );

    assign legal     = f3_legal(req_we, req_funct3);
    assign accept    = req_valid & req_ready;
    assign split     = |wide_be[7:4];
    assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    // Write strobe is cut by reset within the same cycle, not just at the next edge.
    assign mem_wr_en = wr_q & rst_n;

    // Access sequencer with all response and memory-side outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo         <= '0;
            hi         <= '0;
            wr_q       <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    if (accept) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        lo        <= '0;
                        hi        <= '0;
                        req_ready <= 1'b0;
                        if (legal) begin
                            state     <= ACC0;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= wide_be[3:0];
                            mem_wdata <= wide_wdata[31:0];
                            wr_q      <= req_we;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ACC0: begin
                    if (!we_q) begin
                        lo <= mem_rdata;
                    end
                    if (split) begin
                        state     <= ACC1;
                        mem_addr  <= base_addr + ADDR_WIDTH'(4);
                        mem_be    <= wide_be[7:4];
                        mem_wdata <= wide_wdata[63:32];
                        wr_q      <= we_q;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? '0 : load_data;
                        mem_addr   <= '0;
                        mem_be     <= 4'b0000;
                        mem_wdata  <= '0;
                        wr_q       <= 1'b0;
                    end
                end
                ACC1: begin
                    if (!we_q) begin
                        hi <= mem_rdata;
                    end
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= we_q ? '0 : load_data;
                    mem_addr   <= '0;
                    mem_be     <= 4'b0000;
                    mem_wdata  <= '0;
                    wr_q       <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    mem_addr   <= '0;
                    mem_be     <= 4'b0000;
                    mem_wdata  <= '0;
                    wr_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a small byte-enabled RAM model, per-cycle checks of
// the memory-side accesses and the load/store responses.
import lsu_pkg::*;

module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        mem_clr;
    logic [31:0] ram [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_align #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // RAM model: 16 words, combinational read, byte-enabled synchronous write.
    assign mem_rdata = ram[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0000_0000;
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first cycle after accept.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        check("ready_at_issue", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic access(input string t, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [7:0] be, input logic [63:0] wd,
                          input logic [31:0] rdata);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        send(we, f3, a, d);
        check({t, "_acc0_addr"}, mem_addr, al);
        check({t, "_acc0_be"}, 32'(mem_be), 32'(be[3:0]));
        check({t, "_acc0_wr"}, 32'(mem_wr_en), 32'(we));
        if (we) check({t, "_acc0_wdata"}, mem_wdata, wd[31:0]);
        check({t, "_acc0_rv"}, 32'(resp_valid), 32'd0);
        if (be[7:4] != 4'b0000) begin
            @(negedge clk);
            check({t, "_acc1_addr"}, mem_addr, al + 32'd4);
            check({t, "_acc1_be"}, 32'(mem_be), 32'(be[7:4]));
            check({t, "_acc1_wr"}, 32'(mem_wr_en), 32'(we));
            if (we) check({t, "_acc1_wdata"}, mem_wdata, wd[63:32]);
            check({t, "_acc1_rv"}, 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        check({t, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({t, "_resp_err"}, 32'(resp_err), 32'd0);
        check({t, "_resp_rdata"}, resp_rdata, rdata);
        check({t, "_resp_ready"}, 32'(req_ready), 32'd0);
        check({t, "_resp_be"}, 32'(mem_be), 32'd0);
        @(negedge clk);
        check({t, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({t, "_idle_rv"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic illegal(input string t, input logic we, input logic [2:0] f3);
        send(we, f3, 32'h0000_0020, 32'h1234_5678);
        check({t, "_rv"}, 32'(resp_valid), 32'd1);
        check({t, "_err"}, 32'(resp_err), 32'd1);
        check({t, "_rdata"}, resp_rdata, 32'h0000_0000);
        check({t, "_wr"}, 32'(mem_wr_en), 32'd0);
        check({t, "_be"}, 32'(mem_be), 32'd0);
        @(negedge clk);
        check({t, "_ready"}, 32'(req_ready), 32'd1);
        check({t, "_rv_low"}, 32'(resp_valid), 32'd0);
        check({t, "_err_low"}, 32'(resp_err), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_clr    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0000;
        req_wdata  = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check("rst_wr_gated", 32'(mem_wr_en), 32'd0);
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0000_0000);
        check("rst_addr", mem_addr, 32'h0000_0000);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_wdata", mem_wdata, 32'h0000_0000);
        check("rst_wr", 32'(mem_wr_en), 32'd0);

        access("sw_10", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 8'h0F, 64'h0000_0000_DEAD_BEEF, 32'h0);
        access("sb_13", 1'b1, F3_B, 32'h13, 32'h0000_00A5, 8'h08, 64'h0000_0000_A500_0000, 32'h0);
        access("lw_10a", 1'b0, F3_W, 32'h10, 32'h0, 8'h0F, 64'h0, 32'hA5AD_BEEF);

        access("sw_10b", 1'b1, F3_W, 32'h10, 32'h8012_3456, 8'h0F, 64'h0000_0000_8012_3456, 32'h0);
        access("lb_13", 1'b0, F3_B, 32'h13, 32'h0, 8'h08, 64'h0, 32'hFFFF_FF80);
        access("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 8'h08, 64'h0, 32'h0000_0080);
        access("lh_10", 1'b0, F3_H, 32'h10, 32'h0, 8'h03, 64'h0, 32'h0000_3456);
        access("lh_12", 1'b0, F3_H, 32'h12, 32'h0, 8'h0C, 64'h0, 32'hFFFF_8012);
        access("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 8'h0C, 64'h0, 32'h0000_8012);
        access("lb_11", 1'b0, F3_B, 32'h11, 32'h0, 8'h02, 64'h0, 32'h0000_0034);

        access("sw_0e", 1'b1, F3_W, 32'h0E, 32'h1122_3344, 8'h3C, 64'h0000_1122_3344_0000, 32'h0);
        access("lw_0e", 1'b0, F3_W, 32'h0E, 32'h0, 8'h3C, 64'h0, 32'h1122_3344);
        access("lw_10c", 1'b0, F3_W, 32'h10, 32'h0, 8'h0F, 64'h0, 32'h8012_1122);

        access("sw_0c", 1'b1, F3_W, 32'h0C, 32'hAB00_0000, 8'h0F, 64'h0000_0000_AB00_0000, 32'h0);
        access("sw_10d", 1'b1, F3_W, 32'h10, 32'h0000_00CD, 8'h0F, 64'h0000_0000_0000_00CD, 32'h0);
        access("lh_0f", 1'b0, F3_H, 32'h0F, 32'h0, 8'h18, 64'h0, 32'hFFFF_CDAB);
        access("lhu_0f", 1'b0, F3_HU, 32'h0F, 32'h0, 8'h18, 64'h0, 32'h0000_CDAB);

        illegal("ill_st011", 1'b1, 3'b011);
        illegal("ill_st100", 1'b1, 3'b100);
        illegal("ill_ld110", 1'b0, 3'b110);
        illegal("ill_ld011", 1'b0, 3'b011);

        access("sw_wrap", 1'b1, F3_W, 32'hFFFF_FFFE, 32'h5566_7788, 8'h3C, 64'h0000_5566_7788_0000, 32'h0);
        access("lw_wrap", 1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, 8'h3C, 64'h0, 32'h5566_7788);
        access("lw_0", 1'b0, F3_W, 32'h0, 32'h0, 8'h0F, 64'h0, 32'h0000_5566);

        // Reset during the second half of a split store.
        access("clr_0c", 1'b1, F3_W, 32'h0C, 32'h0, 8'h0F, 64'h0, 32'h0);
        access("clr_10", 1'b1, F3_W, 32'h10, 32'h0, 8'h0F, 64'h0, 32'h0);
        send(1'b1, F3_W, 32'h0E, 32'hCAFE_BABE);
        check("mid_acc0_wr", 32'(mem_wr_en), 32'd1);
        @(negedge clk);
        check("mid_acc1_be", 32'(mem_be), 32'h3);
        rst_n = 1'b0;
        #1;
        check("mid_acc1_wr_gated", 32'(mem_wr_en), 32'd0);
        @(negedge clk);
        check("mid_rst_rv", 32'(resp_valid), 32'd0);
        check("mid_rst_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_ready", 32'(req_ready), 32'd1);
        check("mid_post_rv", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("mid_post_rv2", 32'(resp_valid), 32'd0);
        access("mid_lw_0c", 1'b0, F3_W, 32'h0C, 32'h0, 8'h0F, 64'h0, 32'hBABE_0000);
        access("mid_lw_10", 1'b0, F3_W, 32'h10, 32'h0, 8'h0F, 64'h0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
